// File: rtl/boot_loader_if.sv
`default_nettype none
// =============================================================================
// Module   : boot_loader_if
// Purpose  : Byte-stream handshake and instruction-memory write port of the loader.
// Revision : 1.0
// =============================================================================
interface boot_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;

    // master: the loader itself; slave: receiver/memory side
    modport master (
        input  byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );
    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/boot_loader.sv
`default_nettype none
// =============================================================================
// Module   : boot_loader
// Purpose  : Framed byte-stream boot loader; holds the CPU in reset until the
//            image is written. Optional trailing checksum: BOOT_CHECKSUM_EN.
// Revision : 1.0
// =============================================================================
module boot_loader #(
    parameter int         ADDR_WIDTH = 10,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic          clk,
    input  logic          rst,
    boot_loader_if.master bus,
    output logic          cpu_rst_n,
    output logic          boot_done,
    output logic          boot_err
);

`ifdef BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_LEN_HI = 3'd1, S_LEN_LO = 3'd2, S_DATA = 3'd3,
        S_CHK  = 3'd4, S_DONE   = 3'd5, S_ERR    = 3'd6
    } state_t;
    localparam state_t c_END = S_CHK;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_LEN_HI = 3'd1, S_LEN_LO = 3'd2, S_DATA = 3'd3,
        S_DONE = 3'd5, S_ERR    = 3'd6
    } state_t;
    localparam state_t c_END = S_DONE;
`endif

    localparam logic [16:0] c_MAX_CNT = 17'(2 ** ADDR_WIDTH);

    state_t                r_state, w_state_nxt;
    logic [7:0]            r_len_hi;
    logic [15:0]           r_count;
    logic [ADDR_WIDTH:0]   r_word_idx;
    logic [1:0]            r_byte_idx;
    logic [23:0]           r_asm;
    logic                  r_byte_ready;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_wdata;
    logic                  r_boot_done;
    logic                  r_boot_err;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]            r_sum;
`endif

    logic                  w_accept;
    logic [15:0]           w_count;
    logic                  w_count_big;
    logic [ADDR_WIDTH:0]   w_idx_inc;
    logic                  w_word_last;

    assign w_accept    = bus.byte_valid & r_byte_ready;
    assign w_count     = {r_len_hi, bus.byte_data};
    assign w_count_big = ({1'b0, w_count} > c_MAX_CNT);
    assign w_idx_inc   = r_word_idx + 1'b1;
    assign w_word_last = (16'(w_idx_inc) == r_count);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept && bus.byte_data == SYNC_BYTE) w_state_nxt = S_LEN_HI;
            S_LEN_HI: if (w_accept) w_state_nxt = S_LEN_LO;
            S_LEN_LO: begin
                if (w_accept) begin
                    if (w_count_big)         w_state_nxt = S_ERR;
                    else if (w_count == '0)  w_state_nxt = c_END;
                    else                     w_state_nxt = S_DATA;
                end
            end
            S_DATA:   if (w_accept && r_byte_idx == 2'd3 && w_word_last) w_state_nxt = c_END;
`ifdef BOOT_CHECKSUM_EN
            S_CHK:    if (w_accept) w_state_nxt = (bus.byte_data == r_sum) ? S_DONE : S_ERR;
`endif
            default:  w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len_hi     <= '0;
            r_count      <= '0;
            r_word_idx   <= '0;
            r_byte_idx   <= '0;
            r_asm        <= '0;
            r_byte_ready <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_boot_done  <= 1'b0;
            r_boot_err   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            r_sum        <= '0;
`endif
        end else begin
            r_byte_ready <= (w_state_nxt != S_DONE) && (w_state_nxt != S_ERR);
            // Hold the CPU in reset through the cycle of the final write strobe
            r_boot_done  <= (r_state == S_DONE) && !r_mem_we;
            r_boot_err   <= (r_state == S_ERR);
            r_mem_we     <= 1'b0;
            if (w_accept) begin
                case (r_state)
`ifdef BOOT_CHECKSUM_EN
                    S_IDLE:   r_sum <= '0;
`endif
                    S_LEN_HI: r_len_hi <= bus.byte_data;
                    S_LEN_LO: begin
                        r_count    <= w_count;
                        r_word_idx <= '0;
                        r_byte_idx <= '0;
                    end
                    S_DATA: begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        r_asm      <= {r_asm[15:0], bus.byte_data};
`ifdef BOOT_CHECKSUM_EN
                        r_sum      <= r_sum + bus.byte_data;
`endif
                        if (r_byte_idx == 2'd3) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= r_word_idx[ADDR_WIDTH-1:0];
                            r_mem_wdata <= {r_asm, bus.byte_data};
                            r_word_idx  <= w_idx_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.byte_ready = r_byte_ready;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign cpu_rst_n      = r_boot_done;
    assign boot_done      = r_boot_done;
    assign boot_err       = r_boot_err;

endmodule
`default_nettype wire
